// File: rtl/scu_lane_array.sv
// rtl/scu_lane_array.sv - multi-lane zero-skipping saturating MAC array
//
// Each accepted beat carries LANES signed activation/weight pairs. Every lane
// multiplies (S1), accumulates with saturation and a sticky overflow flag
// (S2), and on the group's last beat the lane sums are moved into a one-entry
// output register that holds under backpressure.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input beat handshake
//   in_first, in_last     group framing for the beat
//   lane_mask             per-lane enable, 0 skips the lane for this beat
//   act_in, wt_in         packed signed activations/weights, lane i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready   result handshake
//   psum_out              packed signed group sums, lane i at [i*ACC_W +: ACC_W]
//   sat_flag              lane saturated at least once in the emitted group
//   beat_cnt              beats in the emitted group, saturating

module scu_lane_array #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [LANES-1:0]        lane_mask,
  input  logic [LANES*DATA_W-1:0] act_in,
  input  logic [LANES*DATA_W-1:0] wt_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*ACC_W-1:0]  psum_out,
  output logic [LANES-1:0]        sat_flag,
  output logic [CNT_W-1:0]        beat_cnt
);

  localparam int PW = 2 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // One stall signal for the whole pipeline: only a held, untaken result
  // blocks progress, so every stage advances together or not at all.
  logic en;
  logic accept;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign accept   = in_valid && en;

  // Input-side products and skip decisions.
  logic [PW-1:0]    prod_w [LANES];
  logic [LANES-1:0] skip_w;

  // S1 registers.
  logic             s1_valid;
  logic             s1_first;
  logic             s1_last;
  logic [PW-1:0]    s1_prod [LANES];
  logic [LANES-1:0] s1_skip;

  // S2 (accumulator) registers and their next values.
  logic [ACC_W-1:0] acc_r   [LANES];
  logic [ACC_W-1:0] acc_nxt [LANES];
  logic [LANES-1:0] sat_r;
  logic [LANES-1:0] sat_nxt;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt;
  logic             s2_last;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DATA_W-1:0] a_raw;
    logic [DATA_W-1:0] w_raw;
    logic [PW-1:0]     a_ext;
    logic [PW-1:0]     w_ext;
    logic [ACC_W:0]    p_ext;
    logic [ACC_W:0]    sum;
    logic              ovf;

    assign a_raw = act_in[g*DATA_W +: DATA_W];
    assign w_raw = wt_in[g*DATA_W +: DATA_W];

    // Sign-extend to full product width first; the low PW bits of the
    // product are then the exact two's-complement result.
    assign a_ext     = {{DATA_W{a_raw[DATA_W-1]}}, a_raw};
    assign w_ext     = {{DATA_W{w_raw[DATA_W-1]}}, w_raw};
    assign prod_w[g] = a_ext * w_ext;
    assign skip_w[g] = !lane_mask[g] || (a_raw == '0) || (w_raw == '0);

    // One guard bit above the accumulator: overflow shows up as the two
    // top bits of the sum disagreeing, and the guard bit gives the sign.
    assign p_ext = {{(ACC_W+1-PW){s1_prod[g][PW-1]}}, s1_prod[g]};
    assign sum   = {acc_r[g][ACC_W-1], acc_r[g]} + p_ext;
    assign ovf   = sum[ACC_W] ^ sum[ACC_W-1];

    // A first beat loads rather than adds, so it cannot overflow while
    // ACC_W >= 2*DATA_W; the sticky flag simply restarts at 0.
    assign acc_nxt[g] = s1_first   ? (s1_skip[g] ? '0 : p_ext[ACC_W-1:0]) :
                        s1_skip[g] ? acc_r[g] :
                        ovf        ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) :
                                     sum[ACC_W-1:0];
    assign sat_nxt[g] = s1_first ? 1'b0 : (sat_r[g] | (!s1_skip[g] & ovf));
  end

  assign cnt_nxt = s1_first           ? CNT_W'(1) :
                   (cnt_r == CNT_MAX) ? cnt_r :
                                        cnt_r + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_skip   <= '0;
      s2_last   <= 1'b0;
      sat_r     <= '0;
      cnt_r     <= '0;
      out_valid <= 1'b0;
      psum_out  <= '0;
      sat_flag  <= '0;
      beat_cnt  <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_prod[i] <= '0;
        acc_r[i]   <= '0;
      end
    end else if (en) begin
      // S1: capture products of the accepted beat.
      s1_valid <= accept;
      if (accept) begin
        s1_first <= in_first;
        s1_last  <= in_last;
        s1_skip  <= skip_w;
        for (int i = 0; i < LANES; i++) begin
          s1_prod[i] <= skip_w[i] ? '0 : prod_w[i];
        end
      end

      // S2: accumulate; remember whether this update closes a group.
      s2_last <= s1_valid && s1_last;
      if (s1_valid) begin
        for (int i = 0; i < LANES; i++) begin
          acc_r[i] <= acc_nxt[i];
        end
        sat_r <= sat_nxt;
        cnt_r <= cnt_nxt;
      end

      // Output: with en high any held result is being taken this cycle,
      // so out_valid either reloads or drops.
      out_valid <= s2_last;
      if (s2_last) begin
        for (int i = 0; i < LANES; i++) begin
          psum_out[i*ACC_W +: ACC_W] <= acc_r[i];
        end
        sat_flag <= sat_r;
        beat_cnt <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_scu_lane_array.sv
// tb/tb_scu_lane_array.sv - directed self-checking bench for scu_lane_array

module tb_scu_lane_array;

  localparam int LANES  = 4;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int CNT_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_first;
  logic                    in_last;
  logic [LANES-1:0]        lane_mask;
  logic [LANES*DATA_W-1:0] act_in;
  logic [LANES*DATA_W-1:0] wt_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*ACC_W-1:0]  psum_out;
  logic [LANES-1:0]        sat_flag;
  logic [CNT_W-1:0]        beat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  scu_lane_array #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_last   (in_last),
    .lane_mask (lane_mask),
    .act_in    (act_in),
    .wt_in     (wt_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .psum_out  (psum_out),
    .sat_flag  (sat_flag),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_sum(input int i);
    return psum_out[i*ACC_W +: ACC_W];
  endfunction

  // Presents one beat and holds it until accepted (bounded).
  task automatic send_beat(input bit f, input bit l, input logic [3:0] m,
                           input int a0, input int a1, input int a2, input int a3,
                           input int w0, input int w1, input int w2, input int w3);
    bit go;
    bit accepted;
    accepted  = 1'b0;
    in_first  = f;
    in_last   = l;
    lane_mask = m;
    act_in    = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    wt_in     = {16'(w3), 16'(w2), 16'(w1), 16'(w0)};
    in_valid  = 1'b1;
    for (int k = 0; k < 50; k++) begin
      go = in_ready;
      @(posedge clk);
      #1;
      if (go) begin
        accepted = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    check("beat_accepted", {31'b0, accepted}, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_out(input string tag);
    int k;
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    lane_mask = '0;
    act_in    = '0;
    wt_in     = '0;
    out_ready = 1'b1;

    // Reset state
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_psum_zero", {31'b0, (psum_out == '0)}, 32'd1);
    check("rst_sat", {28'b0, sat_flag}, 32'd0);
    check("rst_cnt", {24'b0, beat_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 3-beat group, latency of two edges after the last accept
    send_beat(1, 0, 4'hF,  2, 1, 0, -2,  3, 1, 5, 3);
    send_beat(0, 0, 4'hF,  4, 1, 0, -2,  5, 1, 5, 3);
    send_beat(0, 1, 4'hF, -1, 1, 0, -2,  6, 1, 5, 3);
    @(posedge clk);
    #1;
    check("t1_early_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_valid", {31'b0, out_valid}, 32'd1);
    check("t1_lane0", lane_sum(0), 32'd20);
    check("t1_lane1", lane_sum(1), 32'd3);
    check("t1_lane2", lane_sum(2), 32'd0);
    check("t1_lane3", lane_sum(3), -32'sd18);
    check("t1_cnt", {24'b0, beat_cnt}, 32'd3);
    check("t1_sat", {28'b0, sat_flag}, 32'd0);
    idle(2);

    // Zero-skip and lane mask
    send_beat(1, 0, 4'b1011,  3, 0, 3, 1,  -4, 9, 3, 7);
    send_beat(0, 1, 4'b1011,  3, 0, 3, 1,  -4, 9, 3, 7);
    wait_out("t2");
    check("t2_lane0", lane_sum(0), -32'sd24);
    check("t2_lane1", lane_sum(1), 32'd0);
    check("t2_lane2", lane_sum(2), 32'd0);
    check("t2_lane3", lane_sum(3), 32'd14);
    check("t2_cnt", {24'b0, beat_cnt}, 32'd2);
    idle(2);

    // Saturation positive and negative, then sticky flag restarts
    send_beat(1, 0, 4'b0011,  32767, -32768, 0, 0,  32767, 32767, 0, 0);
    send_beat(0, 0, 4'b0011,  32767, -32768, 0, 0,  32767, 32767, 0, 0);
    send_beat(0, 1, 4'b0011,  32767, -32768, 0, 0,  32767, 32767, 0, 0);
    wait_out("t3");
    check("t3_lane0_max", lane_sum(0), 32'h7FFF_FFFF);
    check("t3_lane1_min", lane_sum(1), 32'h8000_0000);
    check("t3_sat", {28'b0, sat_flag}, 32'h3);
    check("t3_cnt", {24'b0, beat_cnt}, 32'd3);
    idle(2);
    send_beat(1, 1, 4'b0001,  1, 0, 0, 0,  1, 0, 0, 0);
    wait_out("t3b");
    check("t3b_lane0", lane_sum(0), 32'd1);
    check("t3b_lane1", lane_sum(1), 32'd0);
    check("t3b_sat", {28'b0, sat_flag}, 32'd0);
    check("t3b_cnt", {24'b0, beat_cnt}, 32'd1);
    idle(2);

    // Backpressure: A held while B is in flight
    out_ready = 1'b0;
    send_beat(1, 0, 4'b0001,  1, 0, 0, 0,  10, 0, 0, 0);
    send_beat(0, 1, 4'b0001,  1, 0, 0, 0,  20, 0, 0, 0);
    send_beat(1, 0, 4'b0001,  2, 0, 0, 0,   2, 0, 0, 0);
    send_beat(0, 0, 4'b0001,  3, 0, 0, 0,   3, 0, 0, 0);
    check("t4_in_ready_low", {31'b0, in_ready}, 32'd0);
    check("t4_a_valid", {31'b0, out_valid}, 32'd1);
    check("t4_a_sum", lane_sum(0), 32'd30);
    check("t4_a_cnt", {24'b0, beat_cnt}, 32'd2);
    idle(3);
    check("t4_a_hold", lane_sum(0), 32'd30);
    check("t4_hold_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    send_beat(0, 1, 4'b0001,  4, 0, 0, 0,   4, 0, 0, 0);
    wait_out("t4b");
    check("t4_b_sum", lane_sum(0), 32'd29);
    check("t4_b_cnt", {24'b0, beat_cnt}, 32'd3);
    idle(2);

    // Back-to-back single-beat groups: one result per cycle
    for (int c = 0; c < 7; c++) begin
      if (c < 5) send_beat(1, 1, 4'b0001,  c + 1, 0, 0, 0,  3, 0, 0, 0);
      else idle(1);
      if (c >= 2) begin
        check("t5_valid", {31'b0, out_valid}, 32'd1);
        check("t5_sum", lane_sum(0), 32'(3 * (c - 1)));
        check("t5_cnt", {24'b0, beat_cnt}, 32'd1);
      end
    end
    idle(2);
    check("t5_last_held", lane_sum(0), 32'd15);

    // Reset mid-group
    send_beat(1, 0, 4'b0001,  5, 0, 0, 0,  5, 0, 0, 0);
    send_beat(0, 0, 4'b0001,  5, 0, 0, 0,  5, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    check("t6_rst_psum", {31'b0, (psum_out == '0)}, 32'd1);
    check("t6_rst_cnt", {24'b0, beat_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_beat(1, 0, 4'b0001,  7, 0, 0, 0,  1, 0, 0, 0);
    send_beat(0, 1, 4'b0001,  1, 0, 0, 0,  3, 0, 0, 0);
    wait_out("t6");
    check("t6_sum", lane_sum(0), 32'd10);
    check("t6_cnt", {24'b0, beat_cnt}, 32'd2);
    check("t6_sat", {28'b0, sat_flag}, 32'd0);

    // Beat without first continues from the emitted accumulator
    send_beat(0, 1, 4'b0001,  2, 0, 0, 0,  2, 0, 0, 0);
    wait_out("t7");
    check("t7_sum", lane_sum(0), 32'd14);
    check("t7_cnt", {24'b0, beat_cnt}, 32'd3);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
